// File: rtl/rxf_pkg.sv
// Shared types and helpers for the RX frame filter/packer.
// FSM state encoding, type-field width and byte-count helper.
package rxf_pkg;

    localparam int TYPE_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        DROP
    } rxf_state_e;

    function automatic int unsigned rxf_bytes(
        input int unsigned beats,
        input int unsigned in_w,
        input int unsigned empty
    );
        return beats * (in_w / 8) - empty;
    endfunction

endpackage

// File: rtl/rx_frame_filter_pack_if.sv
// MAC receive beats in, packed FIFO words out.
// master drives the MAC side and fifo_ready; slave is the filter.
interface rx_frame_filter_pack_if #(
    parameter int IN_W  = 64,
    parameter int OUT_W = 256
);
    localparam int EMP_W   = $clog2(IN_W / 8);
    localparam int BYTES_W = $clog2(OUT_W / 8) + 1;

    logic               mac_rx_sop;
    logic               mac_rx_eop;
    logic               mac_rx_valid;
    logic [IN_W-1:0]    mac_rx_data;
    logic [EMP_W-1:0]   mac_rx_empty;

    logic [OUT_W-1:0]   fifo_data_out;
    logic               fifo_data_last;
    logic [BYTES_W-1:0] fifo_data_bytes;
    logic               fifo_data_vld;
    logic               fifo_ready;
    logic               fifo_data_empty;

    modport master (
        output mac_rx_sop, mac_rx_eop, mac_rx_valid,
        output mac_rx_data, mac_rx_empty, fifo_ready,
        input  fifo_data_out, fifo_data_last, fifo_data_bytes,
        input  fifo_data_vld, fifo_data_empty
    );

    modport slave (
        input  mac_rx_sop, mac_rx_eop, mac_rx_valid,
        input  mac_rx_data, mac_rx_empty, fifo_ready,
        output fifo_data_out, fifo_data_last, fifo_data_bytes,
        output fifo_data_vld, fifo_data_empty
    );

endinterface

// File: rtl/rxf_sync_fifo.sv
// Show-ahead synchronous FIFO with free-entry count.
// Read data is forced to zero while empty.
module rxf_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [W-1:0]           wr_data,
    input  logic                   rd_en,
    output logic [W-1:0]           rd_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] free
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;
    logic [AW:0]  count;
    logic         full;
    logic         push;
    logic         pop;

    assign count = wp - rp;
    assign empty = (count == '0);
    assign full  = (count == (AW + 1)'(DEPTH));
    assign free  = (AW + 1)'(DEPTH) - count;
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else if (clr) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rp[AW-1:0]];

endmodule

// File: rtl/rx_frame_filter_pack.sv
// Frame-type filter and MSB-first word packer feeding an output FIFO.
// Define RXF_STATS_EN to build the four packet statistics counters.
module rx_frame_filter_pack
    import rxf_pkg::*;
#(
    parameter int IN_W          = 64,
    parameter int OUT_W         = 256,
    parameter int FIFO_DEPTH    = 64,
    parameter int NUM_TYPES     = 4,
    parameter int MAX_PKT_WORDS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   params_filter_rst,
    input  logic                   params_filter_en,
    input  logic [16*NUM_TYPES-1:0] params_type_tbl,
    input  logic [NUM_TYPES-1:0]   params_type_vld,
    rx_frame_filter_pack_if.slave  rx,
    output logic [31:0]            pkt_in_cnt,
    output logic [31:0]            pkt_pass_cnt,
    output logic [31:0]            pkt_drop_cnt,
    output logic [31:0]            pkt_err_cnt
);
    localparam int BPW     = OUT_W / IN_W;
    localparam int BEAT_W  = $clog2(BPW + 1);
    localparam int BYTES_W = $clog2(OUT_W / 8) + 1;
    localparam int WCNT_W  = $clog2(MAX_PKT_WORDS + 1);
    localparam int FREE_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int FIFO_W  = OUT_W + 1 + BYTES_W;

    rxf_state_e         state, st_n;
    logic [OUT_W-1:0]   acc_q, acc_n;
    logic [BEAT_W-1:0]  beats_q, beats_n;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_n;
    logic               wr_q, wr_n;
    logic [OUT_W-1:0]   wd_q, wd_n;
    logic               wl_q, wl_n;
    logic [BYTES_W-1:0] wb_q, wb_n;

    logic               inc_in, inc_pass, inc_drop, inc_err;
    logic               type_hit, admit, take;
    logic [FREE_W-1:0]  fifo_free, free_eff;
    logic               fifo_empty;
    logic [FIFO_W-1:0]  fifo_rd;
    logic [IN_W-1:0]    keep, beat_d;
    logic [OUT_W-1:0]   base_acc, ins, word;
    logic [BEAT_W-1:0]  base_beats, nbeats;
    logic [WCNT_W-1:0]  base_wcnt;

    always_comb begin
        type_hit = 1'b0;
        for (int k = 0; k < NUM_TYPES; k++) begin
            if (params_type_vld[k] &&
                params_type_tbl[16*k +: TYPE_W] == rx.mac_rx_data[IN_W-1 -: TYPE_W])
                type_hit = 1'b1;
        end
    end

    // a word staged last cycle has not reached the FIFO yet
    assign free_eff = fifo_free - FREE_W'(wr_q);
    assign admit    = (!params_filter_en || type_hit) &&
                      (free_eff >= FREE_W'(MAX_PKT_WORDS));

    assign keep   = rx.mac_rx_eop ?
                    ({IN_W{1'b1}} << {rx.mac_rx_empty, 3'b000}) : '1;
    assign beat_d = rx.mac_rx_data & keep;

    always_comb begin
        st_n       = state;
        acc_n      = acc_q;
        beats_n    = beats_q;
        wcnt_n     = wcnt_q;
        wr_n       = 1'b0;
        wd_n       = '0;
        wl_n       = 1'b0;
        wb_n       = '0;
        inc_in     = 1'b0;
        inc_pass   = 1'b0;
        inc_drop   = 1'b0;
        inc_err    = 1'b0;
        take       = 1'b0;
        base_acc   = acc_q;
        base_beats = beats_q;
        base_wcnt  = wcnt_q;
        ins        = '0;
        word       = '0;
        nbeats     = '0;
        if (rx.mac_rx_valid) begin
            if (rx.mac_rx_sop) begin
                inc_in = 1'b1;
                if (state == PASS) begin
                    wr_n     = 1'b1;
                    wd_n     = acc_q;
                    wl_n     = 1'b1;
                    wb_n     = BYTES_W'(rxf_bytes(int'(beats_q), IN_W, 0));
                    inc_err  = 1'b1;
                    inc_drop = 1'b1;
                    st_n     = rx.mac_rx_eop ? IDLE : DROP;
                    acc_n    = '0;
                    beats_n  = '0;
                    wcnt_n   = '0;
                end else if (admit) begin
                    inc_pass   = 1'b1;
                    take       = 1'b1;
                    base_acc   = '0;
                    base_beats = '0;
                    base_wcnt  = '0;
                end else begin
                    inc_drop = 1'b1;
                    st_n     = rx.mac_rx_eop ? IDLE : DROP;
                end
            end else if (state == PASS) begin
                take = 1'b1;
            end else if (rx.mac_rx_eop) begin
                st_n = IDLE;
            end
        end
        if (take) begin
            ins    = (OUT_W'(beat_d) << (OUT_W - IN_W)) >> (base_beats * IN_W);
            word   = base_acc | ins;
            nbeats = base_beats + 1'b1;
            if (rx.mac_rx_eop) begin
                wr_n    = 1'b1;
                wd_n    = word;
                wl_n    = 1'b1;
                wb_n    = BYTES_W'(rxf_bytes(int'(nbeats), IN_W,
                                             int'(rx.mac_rx_empty)));
                st_n    = IDLE;
                acc_n   = '0;
                beats_n = '0;
                wcnt_n  = '0;
            end else if (nbeats == BEAT_W'(BPW)) begin
                wr_n    = 1'b1;
                wd_n    = word;
                wb_n    = BYTES_W'(OUT_W / 8);
                acc_n   = '0;
                beats_n = '0;
                // oversize packet: close it here and discard the tail
                if (base_wcnt == WCNT_W'(MAX_PKT_WORDS - 1)) begin
                    wl_n    = 1'b1;
                    inc_err = 1'b1;
                    st_n    = DROP;
                    wcnt_n  = '0;
                end else begin
                    st_n    = PASS;
                    wcnt_n  = base_wcnt + 1'b1;
                end
            end else begin
                acc_n   = word;
                beats_n = nbeats;
                wcnt_n  = base_wcnt;
                st_n    = PASS;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc_q   <= '0;
            beats_q <= '0;
            wcnt_q  <= '0;
            wr_q    <= 1'b0;
            wd_q    <= '0;
            wl_q    <= 1'b0;
            wb_q    <= '0;
        end else if (params_filter_rst) begin
            state   <= IDLE;
            acc_q   <= '0;
            beats_q <= '0;
            wcnt_q  <= '0;
            wr_q    <= 1'b0;
            wd_q    <= '0;
            wl_q    <= 1'b0;
            wb_q    <= '0;
        end else begin
            state   <= st_n;
            acc_q   <= acc_n;
            beats_q <= beats_n;
            wcnt_q  <= wcnt_n;
            wr_q    <= wr_n;
            wd_q    <= wd_n;
            wl_q    <= wl_n;
            wb_q    <= wb_n;
        end
    end

    rxf_sync_fifo #(
        .W     (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (params_filter_rst),
        .wr_en   (wr_q),
        .wr_data ({wl_q, wb_q, wd_q}),
        .rd_en   (!fifo_empty && rx.fifo_ready),
        .rd_data (fifo_rd),
        .empty   (fifo_empty),
        .free    (fifo_free)
    );

    assign {rx.fifo_data_last, rx.fifo_data_bytes, rx.fifo_data_out} = fifo_rd;
    assign rx.fifo_data_empty = fifo_empty;
    assign rx.fifo_data_vld   = !fifo_empty;

`ifdef RXF_STATS_EN
    logic [31:0] in_q, pass_q, drop_q, err_q;
    logic        cnt_en;

    assign cnt_en = !params_filter_rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q   <= '0;
            pass_q <= '0;
            drop_q <= '0;
            err_q  <= '0;
        end else if (cnt_en) begin
            if (inc_in)   in_q   <= in_q + 1'b1;
            if (inc_pass) pass_q <= pass_q + 1'b1;
            if (inc_drop) drop_q <= drop_q + 1'b1;
            if (inc_err)  err_q  <= err_q + 1'b1;
        end
    end

    assign pkt_in_cnt   = in_q;
    assign pkt_pass_cnt = pass_q;
    assign pkt_drop_cnt = drop_q;
    assign pkt_err_cnt  = err_q;
`else
    logic unused_stats;
    assign unused_stats = ^{inc_in, inc_pass, inc_drop, inc_err};
    assign pkt_in_cnt   = '0;
    assign pkt_pass_cnt = '0;
    assign pkt_drop_cnt = '0;
    assign pkt_err_cnt  = '0;
`endif

endmodule
